// File: rtl/multicore_pkg.sv
// Shared types for the memory-access stage: load/store size codes,
// MA FSM state encoding, data-memory byte-enable width and misalignment helper.
package multicore_pkg;

    localparam int DMEM_BE_W = 4;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4
    } t_ldop;

    typedef enum logic [1:0] {
        SB = 2'd0,
        SH = 2'd1,
        SW = 2'd2
    } t_sop;

    typedef logic [1:0] t_ma_state;

    localparam t_ma_state MA_IDLE = 2'd0;
    localparam t_ma_state MA_REQ  = 2'd1;
    localparam t_ma_state MA_WAIT = 2'd2;

    // Halfword ops need addr[0]=0, word ops need addr[1:0]=0.
    function automatic logic misaligned(
        input logic [1:0] addr,
        input logic       is_store,
        input t_ldop      ldop,
        input t_sop       sop
    );
        logic half;
        logic word;
        half = is_store ? (sop == SH) : (ldop == LH || ldop == LHU);
        word = is_store ? (sop == SW) : (ldop == LW);
        return (half & addr[0]) | (word & (addr != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the data-memory port.
// Ports: i_addr/i_sop/i_wdata -> o_be/o_wdata; i_addr/i_ldop/i_rdata -> o_rdata.
module mem_lane_align
    import multicore_pkg::*;
(
    input  logic [1:0]           i_addr,
    input  t_sop                 i_sop,
    input  logic [31:0]          i_wdata,
    input  t_ldop                i_ldop,
    input  logic [31:0]          i_rdata,
    output logic [DMEM_BE_W-1:0] o_be,
    output logic [31:0]          o_wdata,
    output logic [31:0]          o_rdata
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_shift = i_rdata >> {i_addr, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_ldop)
            LB:      o_rdata = {{24{w_byte[7]}}, w_byte};
            LBU:     o_rdata = {24'h0, w_byte};
            LH:      o_rdata = {{16{w_half[15]}}, w_half};
            LHU:     o_rdata = {16'h0, w_half};
            default: o_rdata = i_rdata;
        endcase
    end

    always_comb begin
        case (i_sop)
            SB: begin
                o_be    = 4'b0001 << i_addr;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SH: begin
                o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// MA pipeline stage: registers EX results, runs a req/gnt/rvalid data-memory
// transaction, stalls the pipe until it completes and feeds forwarding and WB.
// Ports: i_aclk/i_areset_n; EX inputs i_en..i_sop; dmem o_dmem_*/i_dmem_*;
// o_stall, o_ma_op, o_ma_rdata, WB outputs, o_cu_regwrite, o_bus_err.
// Optional MA_MISALIGN_TRAP_EN adds o_misaligned and o_fault_addr.
module memory_access_unit
    import multicore_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic                 i_aclk,
    input  logic                 i_areset_n,
    input  logic                 i_en,
    input  logic [31:0]          i_exe_calc,
    input  logic [31:0]          i_exe_wdata,
    input  logic [31:0]          i_pcplus4,
    input  logic [4:0]           i_rdest,
    input  logic                 i_cu_regwrite,
    input  logic [1:0]           i_cu_memtoreg,
    input  logic                 i_cu_memwrite,
    input  logic                 i_cu_memaccess,
    input  t_ldop                i_ldop,
    input  t_sop                 i_sop,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic [31:0]          o_dmem_addr,
    output logic [DMEM_BE_W-1:0] o_dmem_be,
    output logic [31:0]          o_dmem_wdata,
    input  logic                 i_dmem_gnt,
    input  logic                 i_dmem_rvalid,
    input  logic [31:0]          i_dmem_rdata,
    output logic                 o_stall,
    output logic [31:0]          o_ma_op,
    output logic [31:0]          o_ma_rdata,
    output logic [31:0]          o_exe_calc,
    output logic [31:0]          o_pcplus4,
    output logic [4:0]           o_rdest,
    output logic [1:0]           o_cu_memtoreg,
`ifdef MA_MISALIGN_TRAP_EN
    output logic                 o_misaligned,
    output logic [31:0]          o_fault_addr,
`endif
    output logic                 o_cu_regwrite,
    output logic                 o_bus_err
);

    localparam int TW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    logic [31:0]          r_exe_calc;
    logic [31:0]          r_wdata;
    logic [31:0]          r_pcplus4;
    logic [4:0]           r_rdest;
    t_ldop                r_ldop;
    t_sop                 r_sop;
    logic                 r_regwrite;
    logic [1:0]           r_memtoreg;
    logic                 r_memwrite;
    logic                 r_memaccess;
    t_ma_state            r_state;
    logic [TW-1:0]        r_timer;
    logic                 r_bus_err;
    logic                 w_stall;
    logic                 w_tmo;
    logic                 w_mis_in;
    logic                 w_flt;
    logic                 w_ld_mem;
    logic [DMEM_BE_W-1:0] w_be;
    logic [31:0]          w_wdata;
    logic [31:0]          w_rdata;

`ifdef MA_MISALIGN_TRAP_EN
    logic        r_mis;
    logic [31:0] r_fault_addr;

    assign w_mis_in = i_en & i_cu_memaccess &
                      misaligned(i_exe_calc[1:0], i_cu_memwrite, i_ldop, i_sop);
    assign w_flt    = r_mis;

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_mis        <= 1'b0;
            r_fault_addr <= 32'h0;
        end else if (!w_stall) begin
            r_mis <= w_mis_in;
            if (w_mis_in)
                r_fault_addr <= i_exe_calc;
        end
    end

    assign o_misaligned = r_mis;
    assign o_fault_addr = r_fault_addr;
`else
    assign w_mis_in = 1'b0;
    assign w_flt    = 1'b0;
`endif

    // The completion cycle (rvalid in MA_WAIT) releases the stall so the
    // next op loads on the same edge WB captures this one.
    assign w_stall  = (r_state == MA_REQ) |
                      ((r_state == MA_WAIT) & ~i_dmem_rvalid);
    assign w_tmo    = w_stall & (MAX_WAIT != 0) &
                      (r_timer == TW'(MAX_WAIT - 1));
    assign w_ld_mem = i_en & i_cu_memaccess & ~w_mis_in;

    always_ff @(posedge i_aclk) begin
        if (!w_stall) begin
            r_exe_calc <= i_exe_calc;
            r_wdata    <= i_exe_wdata;
            r_pcplus4  <= i_pcplus4;
            r_rdest    <= i_rdest;
            r_ldop     <= i_ldop;
            r_sop      <= i_sop;
        end
    end

    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_regwrite  <= 1'b0;
            r_memtoreg  <= 2'b00;
            r_memwrite  <= 1'b0;
            r_memaccess <= 1'b0;
            r_state     <= MA_IDLE;
            r_timer     <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_bus_err <= w_tmo;
            if (!w_stall) begin
                r_regwrite  <= i_en & i_cu_regwrite;
                r_memtoreg  <= i_en ? i_cu_memtoreg : 2'b00;
                r_memwrite  <= i_en & i_cu_memwrite;
                r_memaccess <= i_en & i_cu_memaccess;
                r_state     <= w_ld_mem ? MA_REQ : MA_IDLE;
                r_timer     <= '0;
            end else if (w_tmo) begin
                r_state <= MA_IDLE;
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
                if (r_state == MA_REQ && i_dmem_gnt)
                    r_state <= MA_WAIT;
            end
        end
    end

    mem_lane_align u_align (
        .i_addr  (r_exe_calc[1:0]),
        .i_sop   (r_sop),
        .i_wdata (r_wdata),
        .i_ldop  (r_ldop),
        .i_rdata (i_dmem_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign o_dmem_req    = (r_state == MA_REQ);
    assign o_dmem_we     = r_memwrite;
    assign o_dmem_addr   = {r_exe_calc[31:2], 2'b00};
    assign o_dmem_be     = r_memwrite ? w_be : 4'b1111;
    assign o_dmem_wdata  = w_wdata;
    assign o_stall       = w_stall;
    assign o_ma_op       = r_exe_calc;
    assign o_ma_rdata    = w_rdata;
    assign o_exe_calc    = r_exe_calc;
    assign o_pcplus4     = r_pcplus4;
    assign o_rdest       = r_rdest;
    assign o_cu_memtoreg = r_memtoreg;
    // Aborted, trapped and store ops never write the register file.
    assign o_cu_regwrite = r_regwrite & ~r_memwrite & ~w_stall &
                           ~r_bus_err & ~w_flt;
    assign o_bus_err     = r_bus_err;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed self-checking bench for memory_access_unit (MAX_WAIT=8).
// Covers pass-through, store lanes, load extension, timeout, reset, misalign.
module tb_memory_access_unit;
    import multicore_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_en = 1'b0;
    logic [31:0] i_exe_calc = '0;
    logic [31:0] i_exe_wdata = '0;
    logic [31:0] i_pcplus4 = '0;
    logic [4:0]  i_rdest = '0;
    logic        i_cu_regwrite = 1'b0;
    logic [1:0]  i_cu_memtoreg = '0;
    logic        i_cu_memwrite = 1'b0;
    logic        i_cu_memaccess = 1'b0;
    t_ldop       i_ldop = LW;
    t_sop        i_sop = SW;
    logic        i_dmem_gnt = 1'b0;
    logic        i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = '0;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        o_stall;
    logic [31:0] o_ma_op;
    logic [31:0] o_ma_rdata;
    logic [31:0] o_exe_calc;
    logic [31:0] o_pcplus4;
    logic [4:0]  o_rdest;
    logic [1:0]  o_cu_memtoreg;
    logic        o_cu_regwrite;
    logic        o_bus_err;
`ifdef MA_MISALIGN_TRAP_EN
    logic        o_misaligned;
    logic [31:0] o_fault_addr;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    memory_access_unit #(.MAX_WAIT(8)) dut (
        .i_aclk         (clk),
        .i_areset_n     (rst_n),
        .i_en           (i_en),
        .i_exe_calc     (i_exe_calc),
        .i_exe_wdata    (i_exe_wdata),
        .i_pcplus4      (i_pcplus4),
        .i_rdest        (i_rdest),
        .i_cu_regwrite  (i_cu_regwrite),
        .i_cu_memtoreg  (i_cu_memtoreg),
        .i_cu_memwrite  (i_cu_memwrite),
        .i_cu_memaccess (i_cu_memaccess),
        .i_ldop         (i_ldop),
        .i_sop          (i_sop),
        .o_dmem_req     (o_dmem_req),
        .o_dmem_we      (o_dmem_we),
        .o_dmem_addr    (o_dmem_addr),
        .o_dmem_be      (o_dmem_be),
        .o_dmem_wdata   (o_dmem_wdata),
        .i_dmem_gnt     (i_dmem_gnt),
        .i_dmem_rvalid  (i_dmem_rvalid),
        .i_dmem_rdata   (i_dmem_rdata),
        .o_stall        (o_stall),
        .o_ma_op        (o_ma_op),
        .o_ma_rdata     (o_ma_rdata),
        .o_exe_calc     (o_exe_calc),
        .o_pcplus4      (o_pcplus4),
        .o_rdest        (o_rdest),
        .o_cu_memtoreg  (o_cu_memtoreg),
`ifdef MA_MISALIGN_TRAP_EN
        .o_misaligned   (o_misaligned),
        .o_fault_addr   (o_fault_addr),
`endif
        .o_cu_regwrite  (o_cu_regwrite),
        .o_bus_err      (o_bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_op(input logic we, input logic rw,
                          input logic [31:0] a, input logic [31:0] wd);
        i_en           = 1'b1;
        i_cu_memaccess = 1'b1;
        i_cu_memwrite  = we;
        i_cu_regwrite  = rw;
        i_exe_calc     = a;
        i_exe_wdata    = wd;
    endtask

    task automatic do_load(input string tag, input t_ldop op,
                           input logic [31:0] a, input logic [31:0] rd,
                           input logic [31:0] exp);
        i_ldop = op;
        mem_op(1'b0, 1'b1, a, 32'h0);
        step();
        i_en       = 1'b0;
        i_dmem_gnt = 1'b1;
        @(negedge clk);
        chk({tag, "_req"}, {31'h0, o_dmem_req}, 32'h1);
        chk({tag, "_be"}, {28'h0, o_dmem_be}, 32'hF);
        step();
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = rd;
        @(negedge clk);
        chk({tag, "_stall"}, {31'h0, o_stall}, 32'h0);
        chk({tag, "_data"}, o_ma_rdata, exp);
        chk({tag, "_rw"}, {31'h0, o_cu_regwrite}, 32'h1);
        step();
        i_dmem_rvalid = 1'b0;
    endtask

    initial begin
        int n;
        logic seen;

        #2;
        chk("rst_req", {31'h0, o_dmem_req}, 32'h0);
        chk("rst_stall", {31'h0, o_stall}, 32'h0);
        chk("rst_rw", {31'h0, o_cu_regwrite}, 32'h0);
        chk("rst_err", {31'h0, o_bus_err}, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // ALU pass-through
        i_en          = 1'b1;
        i_exe_calc    = 32'h1234;
        i_cu_regwrite = 1'b1;
        i_pcplus4     = 32'h88;
        i_rdest       = 5'd7;
        step();
        i_en = 1'b0;
        @(negedge clk);
        chk("alu_op", o_ma_op, 32'h1234);
        chk("alu_rw", {31'h0, o_cu_regwrite}, 32'h1);
        chk("alu_stall", {31'h0, o_stall}, 32'h0);
        chk("alu_req", {31'h0, o_dmem_req}, 32'h0);
        chk("alu_pc4", o_pcplus4, 32'h88);
        chk("alu_rd", {27'h0, o_rdest}, 32'd7);
        step();

        // SB with gnt in third REQ cycle, rvalid next
        i_sop = SB;
        mem_op(1'b1, 1'b1, 32'h1003, 32'hAB);
        step();
        i_en = 1'b0;
        n = 0;
        for (int c = 1; c <= 4; c++) begin
            i_dmem_gnt    = (c == 3);
            i_dmem_rvalid = (c == 4);
            @(negedge clk);
            if (o_stall) n++;
            if (c == 1) begin
                chk("sb_req", {31'h0, o_dmem_req}, 32'h1);
                chk("sb_we", {31'h0, o_dmem_we}, 32'h1);
                chk("sb_be", {28'h0, o_dmem_be}, 32'h8);
                chk("sb_wdata", o_dmem_wdata, 32'hABABABAB);
                chk("sb_addr", o_dmem_addr, 32'h1000);
            end
            if (c == 4)
                chk("sb_rw", {31'h0, o_cu_regwrite}, 32'h0);
            step();
        end
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = 1'b0;
        chk("sb_stall_cyc", n, 32'd3);

        // SH upper half
        i_sop = SH;
        mem_op(1'b1, 1'b0, 32'h1006, 32'h5A5AC3D2);
        step();
        i_en = 1'b0;
        @(negedge clk);
        chk("sh_be", {28'h0, o_dmem_be}, 32'hC);
        chk("sh_wdata", o_dmem_wdata, 32'hC3D2C3D2);
        step();
        i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = 1'b1;
        step();
        i_dmem_rvalid = 1'b0;

        // Loads
        do_load("lb", LB, 32'h2001, 32'h00008000, 32'hFFFFFF80);
        do_load("lbu", LBU, 32'h2001, 32'h00008000, 32'h00000080);
        do_load("lhu", LHU, 32'h2002, 32'hBEEF0000, 32'h0000BEEF);
        do_load("lh", LH, 32'h2002, 32'hBEEF0000, 32'hFFFFBEEF);
        do_load("lw", LW, 32'h2004, 32'hCAFEF00D, 32'hCAFEF00D);

        // Timeout: no gnt ever
        i_ldop = LW;
        mem_op(1'b0, 1'b1, 32'h4000, 32'h0);
        step();
        i_en = 1'b0;
        n    = 0;
        seen = 1'b0;
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (o_dmem_req) n++;
            if (o_bus_err) begin
                seen = 1'b1;
                chk("tmo_stall", {31'h0, o_stall}, 32'h0);
                chk("tmo_rw", {31'h0, o_cu_regwrite}, 32'h0);
                chk("tmo_req", {31'h0, o_dmem_req}, 32'h0);
            end
            step();
        end
        chk("tmo_seen", {31'h0, seen}, 32'h1);
        chk("tmo_req_cyc", n, 32'd8);
        @(negedge clk);
        chk("tmo_pulse", {31'h0, o_bus_err}, 32'h0);
        chk("tmo_idle", {31'h0, o_dmem_req}, 32'h0);
        step();

        // Reset in MA_WAIT, late rvalid afterwards
        mem_op(1'b0, 1'b1, 32'h5000, 32'h0);
        step();
        i_en       = 1'b0;
        i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt = 1'b0;
        @(negedge clk);
        chk("wait_stall", {31'h0, o_stall}, 32'h1);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        step();
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h11111111;
        @(negedge clk);
        chk("rstw_req", {31'h0, o_dmem_req}, 32'h0);
        chk("rstw_stall", {31'h0, o_stall}, 32'h0);
        chk("rstw_rw", {31'h0, o_cu_regwrite}, 32'h0);
        step();
        i_dmem_rvalid = 1'b0;

        // Misaligned LW
        i_ldop = LW;
        mem_op(1'b0, 1'b1, 32'h3002, 32'h0);
        step();
        i_en = 1'b0;
        @(negedge clk);
`ifdef MA_MISALIGN_TRAP_EN
        chk("mis_flag", {31'h0, o_misaligned}, 32'h1);
        chk("mis_addr", o_fault_addr, 32'h3002);
        chk("mis_req", {31'h0, o_dmem_req}, 32'h0);
        chk("mis_rw", {31'h0, o_cu_regwrite}, 32'h0);
        step();
        @(negedge clk);
        chk("mis_pulse", {31'h0, o_misaligned}, 32'h0);
        chk("mis_hold", o_fault_addr, 32'h3002);
`else
        chk("mis_req", {31'h0, o_dmem_req}, 32'h1);
        chk("mis_addr", o_dmem_addr, 32'h3000);
        chk("mis_be", {28'h0, o_dmem_be}, 32'hF);
        step();
        i_dmem_gnt = 1'b1;
        step();
        i_dmem_gnt    = 1'b0;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h76543210;
        @(negedge clk);
        chk("mis_data", o_ma_rdata, 32'h76543210);
        step();
        i_dmem_rvalid = 1'b0;
`endif
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
